cache_mem_arbiter: RTL and testbench

- Shares one memory-side read channel and one write channel between the instruction cache (read only) and the data cache (read + write), using the cache rd_*/ret_*/wr_* handshake on both sides.
- Sits between the two cache instances and the AXI bridge.
- Registers each accepted request, arbitrates reads round-robin, and routes return beats back to the owner.
- Blocks any read whose line matches a write still in flight.

---
 rtl/cache_mem_arbiter_pkg.sv | 24 ++
 rtl/cache_mem_arbiter_arb.sv | 32 +++
 rtl/cache_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache-to-memory arbiter slice.
// Provides request type codes, requester IDs and one-hot FSM state encodings.
// Ports: none (package).
package cache_mem_arbiter_pkg;

  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_REQ  = 3'b010,
    R_RESP = 3'b100
  } rstate_t;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_REQ  = 3'b010,
    W_WAIT = 3'b100
  } wstate_t;

endpackage

// File: rtl/cache_mem_arbiter_arb.sv
// Two-way round-robin arbiter between icache and dcache read requests.
// Latency: grant is combinational from req; last_grant updates on the granting edge.
// Ports: req_ic/req_dc in, gnt_ic/gnt_dc out (at most one high), clk/resetn.
module rr_arbiter2
  import cache_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic req_ic,
  input  logic req_dc,
  output logic gnt_ic,
  output logic gnt_dc
);

  logic last_grant;

  // On a tie the requester that did not win last time is served; the
  // register starts at IC so the first tie after reset goes to DC.
  always_comb begin
    gnt_dc = req_dc & (~req_ic | (last_grant == REQ_IC));
    gnt_ic = req_ic & (~req_dc | (last_grant == REQ_DC));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= REQ_IC;
    end else if (gnt_ic | gnt_dc) begin
      last_grant <= gnt_dc ? REQ_DC : REQ_IC;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory read channel (icache + dcache) and one write channel (dcache).
// Latency: rd_rdy same cycle as grant, mem_rd_req next cycle; write buffered one cycle.
// Backpressure: one read and one write outstanding; reads to a line being written stall.
// Ports: ic_rd_*/ic_ret_*, dc_rd_*/dc_ret_*/dc_wr_* cache side; mem_rd_*/mem_ret_*/mem_wr_* bridge side.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ic_rd_req,
  input  logic [2:0]        ic_rd_type,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [DATA_W-1:0] ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [2:0]        dc_rd_type,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [DATA_W-1:0] dc_ret_data,
  input  logic              dc_wr_req,
  input  logic [2:0]        dc_wr_type,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [3:0]        dc_wr_wstrb,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_wr_rdy,
  output logic              mem_rd_req,
  output logic [2:0]        mem_rd_type,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_rdy,
  input  logic              mem_ret_valid,
  input  logic              mem_ret_last,
  input  logic [DATA_W-1:0] mem_ret_data,
  output logic              mem_wr_req,
  output logic [2:0]        mem_wr_type,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [3:0]        mem_wr_wstrb,
  output logic [LINE_W-1:0] mem_wr_data,
  input  logic              mem_wr_rdy,
  input  logic              mem_wr_done
);

  rstate_t rstate, rstate_nxt;
  wstate_t wstate, wstate_nxt;

  logic              rd_owner;
  logic [2:0]        rd_type_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic [2:0]        wbuf_type;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [3:0]        wbuf_wstrb;
  logic [LINE_W-1:0] wbuf_data;

  logic wr_accept, ic_haz, dc_haz, rd_open, gnt_ic, gnt_dc, ic_sel, dc_sel;

  // Ready outputs are gated with resetn so they read 0 while reset is held.
  assign dc_wr_rdy = resetn & (wstate == W_IDLE);
  assign wr_accept = dc_wr_rdy & dc_wr_req;

  // A read may not overtake a write to the same 16-byte line: either the
  // buffered write still in flight, or one being accepted this very cycle.
  assign ic_haz = ((wstate != W_IDLE) & (ic_rd_addr[ADDR_W-1:4] == wbuf_addr[ADDR_W-1:4])) |
                  (wr_accept & (ic_rd_addr[ADDR_W-1:4] == dc_wr_addr[ADDR_W-1:4]));
  assign dc_haz = ((wstate != W_IDLE) & (dc_rd_addr[ADDR_W-1:4] == wbuf_addr[ADDR_W-1:4])) |
                  (wr_accept & (dc_rd_addr[ADDR_W-1:4] == dc_wr_addr[ADDR_W-1:4]));

  assign rd_open = resetn & (rstate == R_IDLE);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req_ic (rd_open & ic_rd_req & ~ic_haz),
    .req_dc (rd_open & dc_rd_req & ~dc_haz),
    .gnt_ic (gnt_ic),
    .gnt_dc (gnt_dc)
  );

  assign ic_rd_rdy = gnt_ic;
  assign dc_rd_rdy = gnt_dc;

  // Read FSM
  always_comb begin
    rstate_nxt = rstate;
    mem_rd_req = 1'b0;
    unique case (rstate)
      R_IDLE: if (gnt_ic | gnt_dc) rstate_nxt = R_REQ;
      R_REQ: begin
        mem_rd_req = 1'b1;
        if (mem_rd_rdy) rstate_nxt = R_RESP;
      end
      R_RESP: if (mem_ret_valid & mem_ret_last) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rstate    <= R_IDLE;
      rd_owner  <= REQ_IC;
      rd_type_q <= '0;
      rd_addr_q <= '0;
    end else begin
      rstate <= rstate_nxt;
      if (gnt_ic | gnt_dc) begin
        rd_owner  <= gnt_dc ? REQ_DC : REQ_IC;
        rd_type_q <= gnt_dc ? dc_rd_type : ic_rd_type;
        rd_addr_q <= gnt_dc ? dc_rd_addr : ic_rd_addr;
      end
    end
  end

  assign mem_rd_type = rd_type_q;
  assign mem_rd_addr = rd_addr_q;

  // Return beats reach only the owner, and only while a response is expected;
  // stray beats at any other time are dropped here.
  assign ic_sel = (rstate == R_RESP) & (rd_owner == REQ_IC);
  assign dc_sel = (rstate == R_RESP) & (rd_owner == REQ_DC);

  assign ic_ret_valid = ic_sel & mem_ret_valid;
  assign ic_ret_last  = ic_sel & mem_ret_last;
  assign ic_ret_data  = ic_sel ? mem_ret_data : '0;
  assign dc_ret_valid = dc_sel & mem_ret_valid;
  assign dc_ret_last  = dc_sel & mem_ret_last;
  assign dc_ret_data  = dc_sel ? mem_ret_data : '0;

  // Write FSM
  always_comb begin
    wstate_nxt = wstate;
    mem_wr_req = 1'b0;
    unique case (wstate)
      W_IDLE: if (dc_wr_req) wstate_nxt = W_REQ;
      W_REQ: begin
        mem_wr_req = 1'b1;
        // A response coinciding with the accept skips the wait state.
        if (mem_wr_rdy) wstate_nxt = mem_wr_done ? W_IDLE : W_WAIT;
      end
      W_WAIT: if (mem_wr_done) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wstate     <= W_IDLE;
      wbuf_type  <= '0;
      wbuf_addr  <= '0;
      wbuf_wstrb <= '0;
      wbuf_data  <= '0;
    end else begin
      wstate <= wstate_nxt;
      if (wr_accept) begin
        wbuf_type  <= dc_wr_type;
        wbuf_addr  <= dc_wr_addr;
        wbuf_wstrb <= dc_wr_wstrb;
        wbuf_data  <= dc_wr_data;
      end
    end
  end

  assign mem_wr_type  = wbuf_type;
  assign mem_wr_addr  = wbuf_addr;
  assign mem_wr_wstrb = wbuf_wstrb;
  assign mem_wr_data  = wbuf_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model of the arbiter.
module tb_cache_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic         ic_rd_req, dc_rd_req, dc_wr_req;
  logic [2:0]   ic_rd_type, dc_rd_type, dc_wr_type;
  logic [31:0]  ic_rd_addr, dc_rd_addr, dc_wr_addr;
  logic [3:0]   dc_wr_wstrb;
  logic [127:0] dc_wr_data;
  logic         ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic [31:0]  ic_ret_data;
  logic         dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_wr_rdy;
  logic [31:0]  dc_ret_data;
  logic         mem_rd_req, mem_rd_rdy, mem_ret_valid, mem_ret_last;
  logic [2:0]   mem_rd_type, mem_wr_type;
  logic [31:0]  mem_rd_addr, mem_ret_data, mem_wr_addr;
  logic         mem_wr_req, mem_wr_rdy, mem_wr_done;
  logic [3:0]   mem_wr_wstrb;
  logic [127:0] mem_wr_data;

  cache_mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
    .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
    .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last), .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
    .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy),
    .mem_wr_done(mem_wr_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Read channel: 0 free, 1 request owed to memory, 2 collecting beats.
  // Write channel: 0 free, 1 request owed to memory, 2 awaiting response.
  bit          m_last_win;           // 0 = IC won the last grant, 1 = DC
  int          m_rph, m_wph;
  bit          m_owner;
  logic [31:0] m_raddr, m_waddr;
  logic [2:0]  m_rtype, m_wtype;
  logic [3:0]  m_wstrb;
  logic [127:0] m_wdata;
  int          bridge_beats;
  bit          ic_granted, dc_granted, wr_taken;

  logic        e_ic_rd_rdy, e_dc_rd_rdy, e_dc_wr_rdy, e_mem_rd_req, e_mem_wr_req;
  logic        e_ic_ret_valid, e_ic_ret_last, e_dc_ret_valid, e_dc_ret_last;
  logic [31:0] e_ic_ret_data, e_dc_ret_data, e_mem_rd_addr, e_mem_wr_addr;
  logic [2:0]  e_mem_rd_type, e_mem_wr_type;
  logic [3:0]  e_mem_wr_wstrb;
  logic [127:0] e_mem_wr_data;

  function automatic bit blocked(input logic [31:0] a);
    return (m_wph != 0 && a[31:4] == m_waddr[31:4]) ||
           (m_wph == 0 && dc_wr_req && a[31:4] == dc_wr_addr[31:4]);
  endfunction

  task automatic model_eval();
    bit el_ic, el_dc;
    {e_ic_rd_rdy, e_dc_rd_rdy, e_dc_wr_rdy, e_mem_rd_req, e_mem_wr_req} = '0;
    {e_ic_ret_valid, e_ic_ret_last, e_dc_ret_valid, e_dc_ret_last} = '0;
    {e_ic_ret_data, e_dc_ret_data, e_mem_rd_addr, e_mem_wr_addr} = '0;
    {e_mem_rd_type, e_mem_wr_type, e_mem_wr_wstrb, e_mem_wr_data} = '0;
    if (!resetn) return;
    el_ic = (m_rph == 0) && ic_rd_req && !blocked(ic_rd_addr);
    el_dc = (m_rph == 0) && dc_rd_req && !blocked(dc_rd_addr);
    if (el_ic && el_dc) begin
      e_dc_rd_rdy = (m_last_win == 1'b0);
      e_ic_rd_rdy = (m_last_win == 1'b1);
    end else begin
      e_ic_rd_rdy = el_ic;
      e_dc_rd_rdy = el_dc;
    end
    e_dc_wr_rdy   = (m_wph == 0);
    e_mem_rd_req  = (m_rph == 1);
    e_mem_rd_addr = m_raddr;
    e_mem_rd_type = m_rtype;
    if (m_rph == 2 && mem_ret_valid) begin
      if (m_owner) begin
        e_dc_ret_valid = 1'b1; e_dc_ret_last = mem_ret_last; e_dc_ret_data = mem_ret_data;
      end else begin
        e_ic_ret_valid = 1'b1; e_ic_ret_last = mem_ret_last; e_ic_ret_data = mem_ret_data;
      end
    end
    e_mem_wr_req   = (m_wph == 1);
    e_mem_wr_addr  = m_waddr;
    e_mem_wr_type  = m_wtype;
    e_mem_wr_wstrb = m_wstrb;
    e_mem_wr_data  = m_wdata;
  endtask

  task automatic compare_all();
    chk("ic_rd_rdy", ic_rd_rdy, e_ic_rd_rdy);
    chk("dc_rd_rdy", dc_rd_rdy, e_dc_rd_rdy);
    chk("dc_wr_rdy", dc_wr_rdy, e_dc_wr_rdy);
    chk("mem_rd_req", mem_rd_req, e_mem_rd_req);
    chk("mem_wr_req", mem_wr_req, e_mem_wr_req);
    chk("ic_ret_valid", ic_ret_valid, e_ic_ret_valid);
    chk("dc_ret_valid", dc_ret_valid, e_dc_ret_valid);
    if (!resetn || e_mem_rd_req) begin
      chk("mem_rd_addr", mem_rd_addr, e_mem_rd_addr);
      chk("mem_rd_type", mem_rd_type, e_mem_rd_type);
    end
    if (!resetn || e_mem_wr_req) begin
      chk("mem_wr_addr", mem_wr_addr, e_mem_wr_addr);
      chk("mem_wr_type", mem_wr_type, e_mem_wr_type);
      chk("mem_wr_wstrb", mem_wr_wstrb, e_mem_wr_wstrb);
      chk("mem_wr_data", mem_wr_data, e_mem_wr_data);
    end
    if (!resetn || e_ic_ret_valid) begin
      chk("ic_ret_last", ic_ret_last, e_ic_ret_last);
      chk("ic_ret_data", ic_ret_data, e_ic_ret_data);
    end
    if (!resetn || e_dc_ret_valid) begin
      chk("dc_ret_last", dc_ret_last, e_dc_ret_last);
      chk("dc_ret_data", dc_ret_data, e_dc_ret_data);
    end
  endtask

  task automatic model_commit();
    if (!resetn) begin
      m_last_win = 1'b0; m_rph = 0; m_wph = 0; m_owner = 1'b0;
      m_raddr = '0; m_rtype = '0; m_waddr = '0; m_wtype = '0; m_wstrb = '0; m_wdata = '0;
      bridge_beats = 0; ic_granted = 1'b0; dc_granted = 1'b0; wr_taken = 1'b0;
      return;
    end
    ic_granted = e_ic_rd_rdy;
    dc_granted = e_dc_rd_rdy;
    wr_taken   = e_dc_wr_rdy && dc_wr_req;
    case (m_rph)
      0: if (e_ic_rd_rdy || e_dc_rd_rdy) begin
        m_owner    = e_dc_rd_rdy;
        m_raddr    = e_dc_rd_rdy ? dc_rd_addr : ic_rd_addr;
        m_rtype    = e_dc_rd_rdy ? dc_rd_type : ic_rd_type;
        m_last_win = m_owner;
        m_rph      = 1;
      end
      1: if (mem_rd_rdy) begin
        m_rph = 2;
        bridge_beats = (m_rtype == 3'b100) ? 4 : 1;
      end
      default: if (mem_ret_valid) begin
        if (bridge_beats > 0) bridge_beats--;
        if (mem_ret_last) m_rph = 0;
      end
    endcase
    case (m_wph)
      0: if (dc_wr_req) begin
        m_waddr = dc_wr_addr; m_wtype = dc_wr_type; m_wstrb = dc_wr_wstrb; m_wdata = dc_wr_data;
        m_wph = 1;
      end
      1: if (mem_wr_rdy) m_wph = mem_wr_done ? 0 : 2;
      default: if (mem_wr_done) m_wph = 0;
    endcase
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic settle();
    #1;
    model_eval();
    compare_all();
  endtask

  task automatic advance();
    model_commit();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic clear_inputs();
    ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
    dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
    dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = 0;
    mem_rd_rdy = 0; mem_ret_valid = 0; mem_ret_last = 0; mem_ret_data = 0;
    mem_wr_rdy = 0; mem_wr_done = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    step();
    step();
    resetn = 1'b1;
  endtask

  // Accept the pending read, then deliver n beats and check they reach the owner only.
  task automatic serve_lit(input int n, input bit to_dc, input logic [31:0] addr, input logic [2:0] typ);
    logic [31:0] d;
    mem_rd_rdy = 1'b1;
    settle();
    chk("srv_mem_rd_req", mem_rd_req, 1);
    chk("srv_mem_rd_addr", mem_rd_addr, addr);
    chk("srv_mem_rd_type", mem_rd_type, typ);
    advance();
    mem_rd_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      mem_ret_valid = 1'b1; mem_ret_data = d; mem_ret_last = (i == n - 1);
      settle();
      if (to_dc) begin
        chk("srv_dc_valid", dc_ret_valid, 1);
        chk("srv_dc_data", dc_ret_data, d);
        chk("srv_dc_last", dc_ret_last, (i == n - 1));
        chk("srv_ic_quiet", ic_ret_valid, 0);
      end else begin
        chk("srv_ic_valid", ic_ret_valid, 1);
        chk("srv_ic_data", ic_ret_data, d);
        chk("srv_ic_last", ic_ret_last, (i == n - 1));
        chk("srv_dc_quiet", dc_ret_valid, 0);
      end
      advance();
    end
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    case ($urandom_range(3))
      0: base = 32'h0000_1000;
      1: base = 32'h0000_1010;
      2: base = 32'h0000_1020;
      default: base = 32'h0000_2000;
    endcase
    return base | (32'($urandom_range(3)) << 2);
  endfunction

  task automatic rand_drive();
    if (ic_granted) ic_rd_req = 1'b0;
    if (!ic_rd_req && $urandom_range(2) == 0) begin
      ic_rd_req = 1'b1; ic_rd_addr = rand_addr();
      ic_rd_type = ($urandom_range(1) == 1) ? 3'b100 : 3'b010;
    end
    if (dc_granted) dc_rd_req = 1'b0;
    if (!dc_rd_req && $urandom_range(2) == 0) begin
      dc_rd_req = 1'b1; dc_rd_addr = rand_addr();
      dc_rd_type = ($urandom_range(1) == 1) ? 3'b100 : 3'b010;
    end
    if (wr_taken) dc_wr_req = 1'b0;
    if (!dc_wr_req && $urandom_range(3) == 0) begin
      dc_wr_req = 1'b1; dc_wr_addr = rand_addr(); dc_wr_type = 3'b100;
      dc_wr_wstrb = 4'($urandom); dc_wr_data = {$urandom, $urandom, $urandom, $urandom};
    end
    mem_rd_rdy = ($urandom_range(1) == 1);
    if (m_rph == 2) begin
      mem_ret_valid = ($urandom_range(2) != 0);
      mem_ret_last  = (bridge_beats == 1);
    end else begin
      mem_ret_valid = ($urandom_range(7) == 0);
      mem_ret_last  = ($urandom_range(1) == 1);
    end
    mem_ret_data = $urandom;
    mem_wr_rdy = ($urandom_range(1) == 1);
    if (m_wph == 2)                    mem_wr_done = ($urandom_range(2) == 0);
    else if (m_wph == 1 && mem_wr_rdy) mem_wr_done = ($urandom_range(3) == 0);
    else                               mem_wr_done = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();
    model_commit();
    @(negedge clk);
    do_reset();
    settle();
    chk("rst_release_wr_rdy", dc_wr_rdy, 1);
    advance();

    // IC-only line read
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0040;
    settle(); chk("t1_ic_rdy", ic_rd_rdy, 1); advance();
    ic_rd_req = 0;
    serve_lit(4, 1'b0, 32'h1C00_0040, 3'b100);
    step();

    // Round-robin ties from reset
    do_reset();
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h0000_0100;
    dc_rd_req = 1; dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_0200;
    settle(); chk("t2_tie1_dc", dc_rd_rdy, 1); chk("t2_tie1_ic", ic_rd_rdy, 0); advance();
    dc_rd_req = 0;
    serve_lit(4, 1'b1, 32'h0000_0200, 3'b100);
    dc_rd_req = 1; dc_rd_addr = 32'h0000_0300;
    settle(); chk("t2_tie2_ic", ic_rd_rdy, 1); chk("t2_tie2_dc", dc_rd_rdy, 0); advance();
    ic_rd_req = 0;
    serve_lit(4, 1'b0, 32'h0000_0100, 3'b100);
    ic_rd_req = 1; ic_rd_addr = 32'h0000_0400;
    settle(); chk("t2_tie3_dc", dc_rd_rdy, 1); chk("t2_tie3_ic", ic_rd_rdy, 0); advance();
    dc_rd_req = 0;
    serve_lit(4, 1'b1, 32'h0000_0300, 3'b100);
    settle(); chk("t2_ic_follow", ic_rd_rdy, 1); advance();
    ic_rd_req = 0;
    serve_lit(4, 1'b0, 32'h0000_0400, 3'b100);

    // Same-line read held behind a write; different line proceeds
    dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_1230;
    dc_wr_wstrb = 4'hF; dc_wr_data = 128'h3333_2222_1111_0000_7777_6666_5555_4444;
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h0000_123C;
    settle(); chk("t3_wr_rdy", dc_wr_rdy, 1); chk("t3_ic_haz_new", ic_rd_rdy, 0); advance();
    dc_wr_req = 0;
    dc_rd_req = 1; dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_1240;
    settle();
    chk("t3_mem_wr_req", mem_wr_req, 1); chk("t3_mem_wr_addr", mem_wr_addr, 32'h0000_1230);
    chk("t3_ic_haz_buf", ic_rd_rdy, 0); chk("t3_dc_other_line", dc_rd_rdy, 1);
    advance();
    dc_rd_req = 0;
    mem_wr_rdy = 1; step(); mem_wr_rdy = 0;
    serve_lit(4, 1'b1, 32'h0000_1240, 3'b100);
    settle(); chk("t3_ic_wait", ic_rd_rdy, 0); advance();
    mem_wr_done = 1;
    settle(); chk("t3_ic_done_cycle", ic_rd_rdy, 0); advance();
    mem_wr_done = 0;
    settle(); chk("t3_ic_after_done", ic_rd_rdy, 1); advance();
    ic_rd_req = 0;
    serve_lit(4, 1'b0, 32'h0000_123C, 3'b100);

    // Uncached word read
    dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h1FE0_01E0;
    settle(); chk("t4_dc_rdy", dc_rd_rdy, 1); advance();
    dc_rd_req = 0;
    serve_lit(1, 1'b1, 32'h1FE0_01E0, 3'b010);
    dc_rd_req = 1; dc_rd_addr = 32'h1FE0_01E4;
    settle(); chk("t4_idle_next", dc_rd_rdy, 1); advance();
    dc_rd_req = 0;
    serve_lit(1, 1'b1, 32'h1FE0_01E4, 3'b010);

    // Write stalled by the bridge; buffer holds steady
    dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_2000; dc_wr_wstrb = 4'h5;
    dc_wr_data = 128'hAAAA_BBBB_CCCC_DDDD_0123_4567_89AB_CDEF;
    step();
    dc_wr_addr = 32'h0000_3000; dc_wr_data = '1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t5_wr_req", mem_wr_req, 1); chk("t5_wr_addr", mem_wr_addr, 32'h0000_2000);
      chk("t5_wr_data", mem_wr_data, 128'hAAAA_BBBB_CCCC_DDDD_0123_4567_89AB_CDEF);
      chk("t5_wr_rdy_low", dc_wr_rdy, 0);
      advance();
    end
    dc_wr_req = 0; mem_wr_rdy = 1; mem_wr_done = 1;
    step();
    mem_wr_rdy = 0; mem_wr_done = 0;
    settle(); chk("t5_back_idle", dc_wr_rdy, 1); chk("t5_no_req", mem_wr_req, 0); advance();

    // Reset in the middle of a DC burst
    dc_rd_req = 1; dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_5000;
    step();
    dc_rd_req = 0; mem_rd_rdy = 1; step(); mem_rd_rdy = 0;
    for (int i = 0; i < 2; i++) begin
      mem_ret_valid = 1; mem_ret_last = 0; mem_ret_data = 32'hBEEF_0000 + i; step();
    end
    mem_ret_valid = 1; mem_ret_data = 32'hBEEF_0002; resetn = 0;
    settle();
    chk("t6_rst_dc_valid", dc_ret_valid, 0); chk("t6_rst_dc_data", dc_ret_data, 0);
    chk("t6_rst_wr_rdy", dc_wr_rdy, 0); chk("t6_rst_rd_req", mem_rd_req, 0);
    advance();
    step();
    resetn = 1; mem_ret_last = 1;
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h0000_6000;
    settle(); chk("t6_stale_beat", dc_ret_valid, 0); chk("t6_ic_rdy", ic_rd_rdy, 1); advance();
    ic_rd_req = 0; mem_ret_valid = 0; mem_ret_last = 0;
    serve_lit(4, 1'b0, 32'h0000_6000, 3'b100);

    // Random traffic
    clear_inputs();
    step();
    for (int c = 0; c < 4000; c++) begin
      rand_drive();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
